// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and builds the IF/ID pipeline register consumed by decode.
module fetch_stage #(
  parameter int unsigned    AWL      = 6,
  parameter int unsigned    DWL      = 32,
  parameter int unsigned    DEPTH    = 2**AWL,
  parameter logic [DWL-1:0] RESET_PC = '0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           StallF,
  input  logic           StallD,
  input  logic           FlushD,
  input  logic           PCSelD,
  input  logic [DWL-1:0] PCBranchD,
  input  logic           JumpD,
  input  logic [DWL-1:0] PCJumpD,
  output logic [AWL-1:0] IMA,
  input  logic [DWL-1:0] IMRD,
  input  logic           IMReady,
  output logic [DWL-1:0] PCF,
  output logic [DWL-1:0] InstrD,
  output logic [DWL-1:0] PCp1D,
  output logic           ValidD,
  output logic [DWL-1:0] FetchCnt
);

  if (DEPTH != 2**AWL) begin : g_depth_chk
    $error("fetch_stage: DEPTH must equal 2**AWL");
  end

  logic [DWL-1:0] pc_q, pc_d;
  logic [DWL-1:0] pcp1_f;
  logic [DWL-1:0] instr_q, instr_d;
  logic [DWL-1:0] pcp1_q, pcp1_d;
  logic           valid_q, valid_d;
  logic [DWL-1:0] cnt_q, cnt_d;
  logic           load_real;

  assign pcp1_f    = pc_q + 1'b1;
  // Upper PC bits alias into the memory; only the low AWL bits address it.
  assign IMA       = pc_q[AWL-1:0];
  assign load_real = !StallD && !FlushD && IMReady;

  always_comb begin
    pc_d = pc_q;
    if (StallF)       pc_d = pc_q;
    else if (JumpD)   pc_d = PCJumpD;
    else if (PCSelD)  pc_d = PCBranchD;
    else if (!IMReady) pc_d = pc_q;
    else              pc_d = pcp1_f;
  end

  always_comb begin
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!StallD) begin
      if (load_real) begin
        instr_d = IMRD;
        pcp1_d  = pcp1_f;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        // Flush and memory wait both insert a bubble.
        instr_d = '0;
        pcp1_d  = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_q;
  assign PCp1D    = pcp1_q;
  assign ValidD   = valid_q;
  assign FetchCnt = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined core.
- Owns the program counter and instruction-memory request, and builds the IF/ID pipeline register.
- Produces InstrD, PCp1D and ValidD for the decode stage.
- Consumes the decode stage's redirect outputs (PCSelD/PCBranchD, JumpD/PCJumpD) and the hazard unit's StallF/StallD/FlushD.

Parameters:
- AWL, 6, instruction-memory word-address width.
- DWL, 32, data/instruction/PC width.
- DEPTH, 2**AWL, instruction-memory depth in words.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  clear IF/ID to bubble.
- PCSelD  in  1  taken-branch redirect from decode.
- PCBranchD  in  DWL  branch target.
- JumpD  in  1  jump redirect from decode.
- PCJumpD  in  DWL  jump target.
- IMA  out  AWL  instruction-memory word address; equals PCF[AWL-1:0].
- IMRD  in  DWL  instruction read data; combinational from IMA.
- IMReady  in  1  IMRD is valid this cycle.
- PCF  out  DWL  current fetch PC.
- InstrD  out  DWL  IF/ID instruction.
- PCp1D  out  DWL  IF/ID PC+1.
- ValidD  out  1  IF/ID holds a real instruction; 0 means bubble.
- FetchCnt  out  DWL  count of instructions accepted into IF/ID.

Behaviour:
- PC is word-addressed: PCp1F = PCF + 1, modulo 2**DWL. Wrap from all-ones to 0 is required, with no error flag.
- Reset (async, any time, including mid-stall or mid-wait):
  - PCF = RESET_PC; InstrD = 0 (NOP); PCp1D = 0; ValidD = 0; FetchCnt = 0.
  - First fetch is presented on IMA in the first cycle after RST deasserts.
- Next-PC select, evaluated each rising edge in this priority order:
  1. StallF = 1: hold PCF.
  2. JumpD = 1: PCF <= PCJumpD. Jump wins if PCSelD is also 1.
  3. PCSelD = 1: PCF <= PCBranchD.
  4. IMReady = 0: hold PCF (memory wait).
  5. Otherwise: PCF <= PCp1F.
- A redirect is taken even when IMReady = 0; the pending fetch is abandoned.
- IF/ID update, in this priority order:
  1. StallD = 1: hold InstrD, PCp1D, ValidD. StallD overrides FlushD.
  2. FlushD = 1: InstrD = 0, PCp1D = 0, ValidD = 0.
  3. IMReady = 0: load bubble (InstrD = 0, PCp1D = 0, ValidD = 0).
  4. Otherwise: InstrD <= IMRD, PCp1D <= PCp1F, ValidD <= 1.
- FetchCnt increments by 1 only when case IF/ID-4 occurs (real load). It wraps modulo 2**DWL.
- Latency: an instruction at PCF appears on InstrD one cycle after the edge where IMReady = 1 and no stall/flush/redirect is active.
- Redirect penalty: the wrong-path instruction fetched in the redirect cycle is discarded by FlushD (driven by the hazard unit); no internal auto-flush.
- IMA is combinational from PCF. IMA ignores PCF bits above AWL, which alias into the memory.
- No combinational path from any input to InstrD/PCp1D/ValidD/FetchCnt; all are registered.

Test Plan:
- Reset then free-run, IMReady = 1, IMRD = 0x1000_0000 + IMA: cycle 1 InstrD = 0x1000_0000, PCp1D = 1, ValidD = 1; cycle 4 PCF = 4, FetchCnt = 4.
- JumpD = 1, PCJumpD = 0x20, and PCSelD = 1, PCBranchD = 0x10 in the same cycle, FlushD = 1: next PCF = 0x20, ValidD = 0, FetchCnt unchanged; following cycle InstrD = IMRD@0x20.
- StallF = StallD = FlushD = 1 for 2 cycles: PCF, InstrD, PCp1D, ValidD, FetchCnt all constant; release resumes at PC+1.
- IMReady = 0 for 3 cycles at PCF = 5: PCF stays 5, ValidD = 0 for 3 cycles; IMReady = 1 loads InstrD = IMRD@5, PCp1D = 6.
- RESET_PC = 0xFFFF_FFFF, free-run: PCp1D = 0 after first fetch, next PCF = 0, IMA = 0.
- Assert RST asynchronously mid-cycle during an IMReady = 0 wait: outputs go to reset values immediately, before the next edge.
